// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the banked data memory.
// Parity cells are built only when DMEM_PARITY_EN is defined.
package dmem_pkg;

    localparam int LANE_W = 8;

`ifdef DMEM_PARITY_EN
    localparam int CELL_W = LANE_W + 1;
`else
    localparam int CELL_W = LANE_W;
`endif

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    function automatic int lanes(input int data_w);
        return data_w / LANE_W;
    endfunction

    function automatic logic even_par(input logic [LANE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_banked_lane.sv
// One byte lane of the data memory: synchronous write, registered read.
// Cell is 9 bits wide when DMEM_PARITY_EN is defined, else 8.
module dmem_banked_lane
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int W      = CELL_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value until the next read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_banked.sv
// Byte-lane banked data memory with valid/ready request and response.
// Optional per-byte parity: define DMEM_PARITY_EN.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int LANES  = lanes(DATA_W),
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    rsp_state_e state_q;
    rsp_state_e state_d;

    logic              in_range;
    logic              rd_fire;
    logic              wr_fire;
    logic              oor_q;
    logic [LANES-1:0]  perr;
    logic [DATA_W-1:0] rdata_raw;
    logic [CELL_W-1:0] wcell [LANES];
    logic [CELL_W-1:0] rcell [LANES];

    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    assign rd_fire  = req_valid && req_ready && !req_we;
    assign wr_fire  = req_valid && req_ready && req_we;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef DMEM_PARITY_EN
        assign wcell[i] = {
            even_par(req_wdata[i*LANE_W +: LANE_W]),
            req_wdata[i*LANE_W +: LANE_W]
        };
        assign perr[i] = rcell[i][LANE_W]
                       ^ even_par(rcell[i][LANE_W-1:0]);
`else
        assign wcell[i] = req_wdata[i*LANE_W +: LANE_W];
        assign perr[i]  = 1'b0;
`endif
        assign rdata_raw[i*LANE_W +: LANE_W] = rcell[i][LANE_W-1:0];

        dmem_banked_lane #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .W      (CELL_W)
        ) u_lane (
            .clk    (clk),
            .resetn (resetn),
            .we     (wr_fire && in_range && req_mask[i]),
            .re     (rd_fire && in_range),
            .addr   (req_addr),
            .wdata  (wcell[i]),
            .rdata  (rcell[i])
        );
    end

    // Response state and out-of-range flag for the held response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RSP_EMPTY;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rd_fire) begin
                oor_q <= !in_range;
            end
        end
    end

    // Next response state and the combinational handshake outputs.
    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        unique case (state_q)
            RSP_EMPTY: begin
                if (rd_fire) begin
                    state_d = RSP_FULL;
                end
            end
            RSP_FULL: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready && !rd_fire) begin
                    state_d = RSP_EMPTY;
                end
            end
            default: state_d = RSP_EMPTY;
        endcase
    end

    assign rsp_rdata = oor_q ? '0 : rdata_raw;
    assign rsp_err   = oor_q || (|perr);

endmodule

// File: tb/tb_dmem_banked.sv
// Directed self-checking bench for dmem_banked (DEPTH=1000).
// Parity steps run only when DMEM_PARITY_EN is defined.
module tb_dmem_banked;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1000;
    localparam int LANES  = DATA_W / 8;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_mask;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_banked #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a,
                      input logic [LANES-1:0] m,
                      input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_mask  = m;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_mask  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        resetn = 1'b1;
        tick();

        wr(5, 4'hF, 32'hDEADBEEF);
        chk("wr_no_rsp", 32'(rsp_valid), 32'h0);
        rd(5);
        chk("rd5_valid", 32'(rsp_valid), 32'h1);
        chk("rd5_data", rsp_rdata, 32'hDEADBEEF);
        chk("rd5_err", 32'(rsp_err), 32'h0);
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'h0);

        wr(5, 4'h3, 32'h00001234);
        rd(5);
        chk("part_data", rsp_rdata, 32'hDEAD1234);

        wr(6, 4'hF, 32'hCAFEF00D);
        rsp_ready = 1'b0;
        rd(5);
        req_valid = 1'b1;
        req_addr  = 6;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_data", rsp_rdata, 32'hDEAD1234);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        chk("b2b_valid", 32'(rsp_valid), 32'h1);
        chk("b2b_data", rsp_rdata, 32'hCAFEF00D);
        tick();
        chk("b2b_drain", 32'(rsp_valid), 32'h0);

        wr(9, 4'hF, 32'h11223344);
        rd(9);
        chk("raw_data", rsp_rdata, 32'h11223344);

        wr(999, 4'hF, 32'h99999999);
        wr(10'd1000, 4'hF, 32'h12345678);
        rd(10'd1000);
        chk("oor_valid", 32'(rsp_valid), 32'h1);
        chk("oor_data", rsp_rdata, 32'h0);
        chk("oor_err", 32'(rsp_err), 32'h1);
        rd(999);
        chk("a999_data", rsp_rdata, 32'h99999999);
        chk("a999_err", 32'(rsp_err), 32'h0);

        wr(999, 4'h0, 32'h0);
        rd(999);
        chk("mask0_data", rsp_rdata, 32'h99999999);

        wr(7, 4'hF, 32'h01020304);
        rd(7);
        chk("a7_data", rsp_rdata, 32'h01020304);
        chk("a7_err", 32'(rsp_err), 32'h0);
`ifdef DMEM_PARITY_EN
        dut.g_lane[2].u_lane.mem[7][3] = ~dut.g_lane[2].u_lane.mem[7][3];
        rd(7);
        chk("par_err", 32'(rsp_err), 32'h1);
        chk("par_data", rsp_rdata, 32'h010A0304);
        rd(6);
        chk("par_clean", 32'(rsp_err), 32'h0);
`endif

        rsp_ready = 1'b0;
        rd(10'd1000);
        chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'h0);
        chk("arst_data", rsp_rdata, 32'h0);
        chk("arst_err", 32'(rsp_err), 32'h0);
        tick();
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
